// File: rtl/conv_pkg.sv
// Shared types and defaults for the feature-map engines; the pool sweep
// adds its state enum, firing threshold and leak magnitude here.
package conv_pkg;

    localparam int DEFAULT_BITS_PER_COORDINATE_IN = 8;
    localparam int DEFAULT_OUT_CHANNELS           = 2;
    localparam int DEFAULT_BITS_PER_NEURON        = 8;
    localparam int DEFAULT_IMG_WIDTH              = 2;
    localparam int DEFAULT_IMG_HEIGHT             = 2;
    localparam int DEFAULT_POOL_THRESHOLD         = 10;
    localparam int DEFAULT_POOL_DECAY             = 2;

    typedef struct packed {
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] x;
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] y;
    } vec2_t;

    // Channel c occupies slice [c] of the packed word.
    typedef logic [DEFAULT_OUT_CHANNELS-1:0][DEFAULT_BITS_PER_NEURON-1:0] fm_array_t;

    typedef enum logic [2:0] {
        POOL_IDLE  = 3'd0,
        POOL_READ  = 3'd1,
        POOL_WAIT  = 3'd2,
        POOL_WRITE = 3'd3,
        POOL_EMIT  = 3'd4,
        POOL_DONE  = 3'd5
    } pool_state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pool_sweep_neuron_update.sv
// pool_neuron_update: combinational leak/threshold for one signed channel.
// Evaluated one bit wider than the state so the leak can never wrap.
module pool_neuron_update
    import conv_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS_PER_NEURON,
    parameter int THRESHOLD = DEFAULT_POOL_THRESHOLD,
    parameter int DECAY     = DEFAULT_POOL_DECAY
) (
    input  logic [BITS-1:0] state_i,
    output logic [BITS-1:0] state_o,
    output logic            fire_o
);

    localparam logic signed [BITS:0] THR_EXT  = (BITS+1)'(THRESHOLD);
    localparam logic signed [BITS:0] DEC_EXT  = (BITS+1)'(DECAY);
    localparam logic signed [BITS:0] ZERO_EXT = (BITS+1)'(0);

    logic signed [BITS:0] s_ext_s;
    logic signed [BITS:0] dec_sum_s;
    logic signed [BITS:0] inc_sum_s;

    // Fire at or above threshold, otherwise leak toward zero without crossing it.
    always_comb begin
        s_ext_s   = signed'({state_i[BITS-1], state_i});
        dec_sum_s = s_ext_s - DEC_EXT;
        inc_sum_s = s_ext_s + DEC_EXT;
        fire_o    = 1'b0;
        state_o   = '0;
        if (s_ext_s >= THR_EXT) begin
            fire_o  = 1'b1;
            state_o = '0;
        end else if (s_ext_s > ZERO_EXT) begin
            if (dec_sum_s < ZERO_EXT) begin
                state_o = '0;
            end else begin
                state_o = dec_sum_s[BITS-1:0];
            end
        end else if (s_ext_s < ZERO_EXT) begin
            if (inc_sum_s > ZERO_EXT) begin
                state_o = '0;
            end else begin
                state_o = inc_sum_s[BITS-1:0];
            end
        end else begin
            state_o = '0;
        end
    end

endmodule

// File: rtl/pool_sweep.sv
// pool_sweep: walks the feature-map grid through the arbiter pool ports,
// applies leak/threshold per channel, writes back and emits spike events.
// Optional POOL_SWEEP_STATS_EN adds a saturating spike_count output.
module pool_sweep
    import conv_pkg::*;
#(
    parameter int COORD_BITS       = DEFAULT_BITS_PER_COORDINATE_IN,
    parameter int CHANNELS         = DEFAULT_OUT_CHANNELS,
    parameter int BITS_PER_CHANNEL = DEFAULT_BITS_PER_NEURON,
    parameter int IMG_WIDTH        = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT       = DEFAULT_IMG_HEIGHT,
    parameter int THRESHOLD        = DEFAULT_POOL_THRESHOLD,
    parameter int DECAY            = DEFAULT_POOL_DECAY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                read_req,
    output vec2_t               coord_get,
    input  logic                read_ready,
    input  fm_array_t           data_out,
    output logic                write_req,
    output vec2_t               coord_wtr,
    output fm_array_t           data_in,
    input  logic                write_ready,
    output logic                spike_valid,
    input  logic                spike_ready,
    output vec2_t               spike_coord,
    output logic [CHANNELS-1:0] spike_vec
`ifdef POOL_SWEEP_STATS_EN
    ,
    output logic [31:0]         spike_count
`endif
);

    localparam logic [COORD_BITS-1:0] X_LAST    = COORD_BITS'(IMG_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST    = COORD_BITS'(IMG_HEIGHT - 1);
    localparam logic [COORD_BITS-1:0] COORD_ONE = COORD_BITS'(1);

    pool_state_t state_q, state_d, adv_state_s;
    logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d, adv_x_s, adv_y_s;
    logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] upd_s, upd_q, upd_d;
    logic [CHANNELS-1:0] fire_s, fire_q, fire_d;

    logic                busy_q, done_q, read_req_q, write_req_q, spike_valid_q;
    logic [CHANNELS-1:0] spike_vec_q;
    vec2_t               coord_s;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pool_neuron_update #(
            .BITS      (BITS_PER_CHANNEL),
            .THRESHOLD (THRESHOLD),
            .DECAY     (DECAY)
        ) u_update (
            .state_i (data_out[c]),
            .state_o (upd_s[c]),
            .fire_o  (fire_s[c])
        );
    end

    // Next coordinate in raster order, or DONE after the last one.
    always_comb begin
        adv_x_s     = x_q + COORD_ONE;
        adv_y_s     = y_q;
        adv_state_s = POOL_READ;
        if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
                adv_x_s     = x_q;
                adv_y_s     = y_q;
                adv_state_s = POOL_DONE;
            end else begin
                adv_x_s     = '0;
                adv_y_s     = y_q + COORD_ONE;
                adv_state_s = POOL_READ;
            end
        end else begin
            adv_state_s = POOL_READ;
        end
    end

    // Sweep sequencing: next state, coordinate and captured update.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        upd_d   = upd_q;
        fire_d  = fire_q;
        case (state_q)
            POOL_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = POOL_READ;
                end else begin
                    state_d = POOL_IDLE;
                end
            end
            POOL_READ: begin
                if (read_ready) begin
                    state_d = POOL_WAIT;
                end else begin
                    state_d = POOL_READ;
                end
            end
            POOL_WAIT: begin
                upd_d   = upd_s;
                fire_d  = fire_s;
                state_d = POOL_WRITE;
            end
            POOL_WRITE: begin
                if (!write_ready) begin
                    state_d = POOL_WRITE;
                end else if (|fire_q) begin
                    state_d = POOL_EMIT;
                end else begin
                    state_d = adv_state_s;
                    x_d     = adv_x_s;
                    y_d     = adv_y_s;
                end
            end
            POOL_EMIT: begin
                if (spike_ready) begin
                    state_d = adv_state_s;
                    x_d     = adv_x_s;
                    y_d     = adv_y_s;
                end else begin
                    state_d = POOL_EMIT;
                end
            end
            POOL_DONE: begin
                state_d = POOL_IDLE;
            end
            default: begin
                state_d = POOL_IDLE;
            end
        endcase
    end

    // State, coordinate and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= POOL_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            upd_q   <= '0;
            fire_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            upd_q   <= upd_d;
            fire_q  <= fire_d;
        end
    end

    // Handshake outputs are decoded from the next state so they flop with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            read_req_q    <= 1'b0;
            write_req_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_vec_q   <= '0;
        end else begin
            busy_q        <= (state_d inside {POOL_READ, POOL_WAIT, POOL_WRITE, POOL_EMIT});
            done_q        <= (state_d == POOL_DONE);
            read_req_q    <= (state_d == POOL_READ);
            write_req_q   <= (state_d == POOL_WRITE);
            spike_valid_q <= (state_d == POOL_EMIT);
            spike_vec_q   <= (state_d == POOL_EMIT) ? fire_d : '0;
        end
    end

    assign coord_s.x   = x_q;
    assign coord_s.y   = y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign read_req    = read_req_q;
    assign write_req   = write_req_q;
    assign spike_valid = spike_valid_q;
    assign spike_vec   = spike_vec_q;
    assign coord_get   = coord_s;
    assign coord_wtr   = coord_s;
    assign spike_coord = coord_s;
    assign data_in     = upd_q;

`ifdef POOL_SWEEP_STATS_EN
    logic [31:0] spike_count_q, spike_count_d;
    logic [32:0] count_sum_s;

    // Saturating count of fired channels, cleared when a sweep is accepted.
    always_comb begin
        count_sum_s   = {1'b0, spike_count_q} + {27'd0, popcount32(32'(spike_vec_q))};
        spike_count_d = spike_count_q;
        if ((state_q == POOL_IDLE) && start) begin
            spike_count_d = '0;
        end else if ((state_q == POOL_EMIT) && spike_ready) begin
            spike_count_d = count_sum_s[32] ? 32'hFFFF_FFFF : count_sum_s[31:0];
        end else begin
            spike_count_d = spike_count_q;
        end
    end

    // Spike counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count_q <= '0;
        end else begin
            spike_count_q <= spike_count_d;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule

// File: doc/pool_sweep.md
# pool_sweep

Pooling-phase neuron update engine on the pool side of the feature-map BRAM arbiter. On `start` it walks every coordinate of the feature-map grid, reads the packed neuron states through the arbiter pool read port and applies per-channel leak and threshold. It writes the updated states back through the pool write port and emits one spike event per coordinate that fired. It is the consumer/producer pair for the arbiter during `conv_or_pool = 0`.

## Interface
Parameters:
- `COORD_BITS`, `DEFAULT_BITS_PER_COORDINATE_IN`: width of each coordinate component.
- `CHANNELS`, `DEFAULT_OUT_CHANNELS`: feature maps per coordinate.
- `BITS_PER_CHANNEL`, `DEFAULT_BITS_PER_NEURON`: signed two's-complement neuron state width.
- `IMG_WIDTH`, `DEFAULT_IMG_WIDTH`: x extent.
- `IMG_HEIGHT`, `DEFAULT_IMG_HEIGHT`: y extent.
- `THRESHOLD`, `DEFAULT_POOL_THRESHOLD`: firing level; signed, applied per channel.
- `DECAY`, `DEFAULT_POOL_DECAY`: non-negative leak magnitude per sweep.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle sweep request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last coordinate is written and its event is taken.
- `read_req`  out  1  arbiter pool read request.
- `coord_get`  out  vec2_t  read coordinate.
- `read_ready`  in  1  arbiter grant; a read is accepted on `read_req && read_ready`.
- `data_out`  in  fm_array_t  read data; valid the cycle after acceptance.
- `write_req`  out  1  arbiter pool write request.
- `coord_wtr`  out  vec2_t  write coordinate.
- `data_in`  out  fm_array_t  write data.
- `write_ready`  in  1  a write is accepted on `write_req && write_ready`.
- `spike_valid`  out  1  spike event valid.
- `spike_ready`  in  1  downstream accepts on `spike_valid && spike_ready`.
- `spike_coord`  out  vec2_t  event coordinate.
- `spike_vec`  out  CHANNELS  one bit per channel that fired.
- `spike_count`  out  32  only with `POOL_SWEEP_STATS_EN` (see Configuration).

## Operation
- States: IDLE, READ, WAIT, WRITE, EMIT, DONE.
- IDLE: if `start` is high, clear x and y to 0 and go to READ.
- READ: hold `read_req` high with `coord_get = {x, y}` until `read_ready` is high, then go to WAIT.
- WAIT: capture `data_out` and compute the update. Go to WRITE.
- Per-channel update, with s being the channel state:
  - If s >= THRESHOLD: the channel fires, its spike bit is 1 and its new state is 0.
  - Else if s > 0: new state = max(s - DECAY, 0).
  - Else if s < 0: new state = min(s + DECAY, 0).
  - Else: new state = 0.
  - Arithmetic is performed in BITS_PER_CHANNEL+1 bits, so no wrap-around is possible.
- WRITE: hold `write_req`, `coord_wtr` and `data_in` stable until `write_ready` is high. Then:
  - go to EMIT if any spike bit is set;
  - otherwise advance the coordinate.
- EMIT: hold `spike_valid`, `spike_coord` and `spike_vec` stable until `spike_ready` is high, then advance the coordinate.
- Coordinate advance:
  - x increments first.
  - At x = IMG_WIDTH-1, x wraps to 0 and y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), go to DONE instead.
  - Otherwise return to READ.
- DONE: pulse `done` for one cycle, then go to IDLE.
- `start` while busy is ignored.
- Only one of `read_req` and `write_req` is ever asserted at a time. Request lines never drop before acceptance.

## Timing
- Reset values: all outputs 0, state IDLE, x = y = 0, `spike_count` = 0.
- Reset mid-sweep: state is abandoned immediately, and no partial write completes after `rst_n` falls.
- With every ready input held high:
  - 3 cycles per non-firing coordinate, 4 cycles per firing coordinate.
  - `done` is asserted 3·W·H + F + 1 cycles after `start` (F = number of firing coordinates).
- `busy` rises the cycle after `start` and falls together with the `done` pulse.
- All outputs are registered.

## Configuration
- `POOL_SWEEP_STATS_EN` defined: `spike_count` exists.
  - Increments by the popcount of `spike_vec` on each EMIT handshake.
  - Cleared on accepted `start`.
  - Saturates at 2^32-1.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Structure
- `conv_pkg` gains:
  - `pool_state_t` (the state enum);
  - `DEFAULT_POOL_THRESHOLD` and `DEFAULT_POOL_DECAY`.
- `vec2_t` and `fm_array_t` are reused from the package.
- Sub-module `pool_neuron_update`: purely combinational single-channel leak/threshold. It is instantiated CHANNELS times in a generate loop.

## Test plan
- 2×2 grid, CHANNELS=2, 8-bit states, THRESHOLD=10, DECAY=2; all states 0, readies high:
  - no spike events;
  - all writes are 0;
  - `done` asserted 13 cycles after `start`.
- Coord (1,0) holds {12, 5}: one event with `spike_coord`=(1,0) and `spike_vec`=2'b01; written state {0, 3}.
- States {-1, 1} with DECAY=2: written {0, 0}. States {-7, 127}: written {-5, 0} and `spike_vec`=2'b10, with no overflow.
- `read_ready` low for 5 cycles, `write_ready` low for 3 cycles, `spike_ready` low for 4 cycles:
  - each request is held with stable coordinate and data;
  - no duplicate reads, writes or events.
- `rst_n` pulsed low during WRITE at (1,1):
  - all outputs 0 immediately;
  - a new `start` restarts at (0,0).
- With `POOL_SWEEP_STATS_EN`, three firing channels across the sweep: `spike_count`=3, and it resets to 0 on the next `start`.
